// File: rtl/fft_pair_buffer.sv
// Buffers the first half of a frame, then presents (x[n], x[n+HALF_LEN]) pairs to a
// sum/diff butterfly, each pair held two cycles (sum phase, then diff phase).
module fft_pair_buffer #(
    parameter int DATA_FFT_SIZE = 16,
    parameter int HALF_LEN      = 8
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic                     i_valid,
    output logic                     o_ready,
    input  logic [DATA_FFT_SIZE-1:0] i_data_i,
    input  logic [DATA_FFT_SIZE-1:0] i_data_q,
    output logic                     o_en,
    output logic                     o_phase,
    output logic [DATA_FFT_SIZE-1:0] o_data_in0_i,
    output logic [DATA_FFT_SIZE-1:0] o_data_in0_q,
    output logic [DATA_FFT_SIZE-1:0] o_data_in1_i,
    output logic [DATA_FFT_SIZE-1:0] o_data_in1_q,
    output logic                     o_last
);
    localparam int CW = (HALF_LEN > 1) ? $clog2(HALF_LEN) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(HALF_LEN - 1);

    typedef enum logic [1:0] {FILL, PAIR, HOLD} state_t;

    state_t                   r_state, w_state_nxt;
    logic [CW-1:0]            r_cnt, w_cnt_nxt;
    logic [DATA_FFT_SIZE-1:0] r_buf_i [HALF_LEN];
    logic [DATA_FFT_SIZE-1:0] r_buf_q [HALF_LEN];
    logic                     w_accept;

    assign o_ready  = !i_reset && (r_state != HOLD);
    assign w_accept = i_valid && o_ready;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= FILL;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            FILL: if (w_accept) begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (r_cnt == LAST_IDX) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = PAIR;
                end
            end
            PAIR: if (w_accept) w_state_nxt = HOLD;
            HOLD: begin
                // o_last already reflects the pair being held, so it decides the frame end.
                if (o_last) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = FILL;
                end else begin
                    w_cnt_nxt   = r_cnt + 1'b1;
                    w_state_nxt = PAIR;
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = FILL;
            end
        endcase
    end

    // No reset on the sample store; stale contents are never presented.
    always_ff @(posedge i_clk) begin
        if (w_accept && r_state == FILL) begin
            r_buf_i[r_cnt] <= i_data_i;
            r_buf_q[r_cnt] <= i_data_q;
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            o_en         <= 1'b0;
            o_phase      <= 1'b0;
            o_last       <= 1'b0;
            o_data_in0_i <= '0;
            o_data_in0_q <= '0;
            o_data_in1_i <= '0;
            o_data_in1_q <= '0;
        end else begin
            case (r_state)
                PAIR: begin
                    if (w_accept) begin
                        o_data_in0_i <= r_buf_i[r_cnt];
                        o_data_in0_q <= r_buf_q[r_cnt];
                        o_data_in1_i <= i_data_i;
                        o_data_in1_q <= i_data_q;
                        o_en         <= 1'b1;
                        o_phase      <= 1'b0;
                        o_last       <= (r_cnt == LAST_IDX);
                    end else begin
                        o_en <= 1'b0;
                    end
                end
                HOLD: begin
                    o_en    <= 1'b1;
                    o_phase <= 1'b1;
                end
                default: o_en <= 1'b0;
            endcase
        end
    end
endmodule

// File: tb/tb_fft_pair_buffer.sv
// Directed bench for fft_pair_buffer at HALF_LEN=4, 16-bit samples; Q is always -I.
module tb_fft_pair_buffer;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         valid;
    logic         ready;
    logic [W-1:0] di, dq;
    logic         en, ph, last;
    logic [W-1:0] in0_i, in0_q, in1_i, in1_q;

    int total = 0;
    int bad   = 0;

    fft_pair_buffer #(.DATA_FFT_SIZE(W), .HALF_LEN(4)) dut (
        .i_clk(clk), .i_reset(rst), .i_valid(valid), .o_ready(ready),
        .i_data_i(di), .i_data_q(dq), .o_en(en), .o_phase(ph),
        .o_data_in0_i(in0_i), .o_data_in0_q(in0_q),
        .o_data_in1_i(in1_i), .o_data_in1_q(in1_q), .o_last(last)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] neg(input logic [W-1:0] a);
        return ~a + 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [66:0] obs, input logic [66:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one cycle: present inputs, check o_ready for this cycle, then step past the edge.
    task automatic tick(input logic v, input logic [W-1:0] d, input logic exp_rdy);
        valid = v;
        di    = d;
        dq    = neg(d);
        #2;
        chk("ready", {66'd0, ready}, {66'd0, exp_rdy});
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic e, input logic p, input logic l,
                           input logic [W-1:0] a, input logic [W-1:0] b);
        chk(tag, {en, ph, last, in0_i, in0_q, in1_i, in1_q},
                 {e, p, l, a, neg(a), b, neg(b)});
    endtask

    task automatic chk_idle(input string tag, input logic [W-1:0] a, input logic [W-1:0] b);
        chk(tag, {3'b000, en, in0_i, in0_q, in1_i, in1_q},
                 {3'b000, 1'b0, a, neg(a), b, neg(b)});
    endtask

    // Present sample b in PAIR, expect (a,b) in sum then diff phase.
    task automatic pair(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic l);
        tick(1'b1, b, 1'b1);
        chk_out({tag, "_sum"}, 1'b1, 1'b0, l, a, b);
        tick(1'b1, b, 1'b0);
        chk_out({tag, "_diff"}, 1'b1, 1'b1, l, a, b);
    endtask

    initial begin
        rst = 1'b1; valid = 1'b0; di = '0; dq = '0;
        #2;
        chk("rst_ready", {66'd0, ready}, 67'd0);
        chk_out("rst_out", 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Frame 1: continuous valid, samples 1..8
        for (int k = 1; k <= 4; k++) tick(1'b1, W'(k), 1'b1);
        chk_idle("fill1_done", 16'd0, 16'd0);
        pair("p15", 16'd1, 16'd5, 1'b0);
        pair("p26", 16'd2, 16'd6, 1'b0);
        pair("p37", 16'd3, 16'd7, 1'b0);
        pair("p48", 16'd4, 16'd8, 1'b1);

        // Frame 2 follows directly: sample 9 accepted right after the (4,8) diff cycle
        tick(1'b1, 16'd9, 1'b1);
        chk_idle("fill2_first", 16'd4, 16'd8);
        for (int k = 10; k <= 12; k++) tick(1'b1, W'(k), 1'b1);
        pair("p913", 16'd9, 16'd13, 1'b0);
        pair("p1014", 16'd10, 16'd14, 1'b0);
        pair("p1115", 16'd11, 16'd15, 1'b0);
        pair("p1216", 16'd12, 16'd16, 1'b1);

        // Frame 3: valid toggling 1,0
        for (int k = 31; k <= 34; k++) begin
            tick(1'b1, W'(k), 1'b1);
            tick(1'b0, 16'd0, 1'b1);
        end
        chk_idle("gap_fill", 16'd12, 16'd16);
        for (int k = 0; k < 4; k++) begin
            tick(1'b1, W'(35 + k), 1'b1);
            chk_out("gap_sum", 1'b1, 1'b0, k == 3, W'(31 + k), W'(35 + k));
            tick(1'b0, 16'd0, 1'b0);
            chk_out("gap_diff", 1'b1, 1'b1, k == 3, W'(31 + k), W'(35 + k));
            tick(1'b0, 16'd0, 1'b1);
            chk_idle("gap_idle", W'(31 + k), W'(35 + k));
        end

        // Reset mid-frame, asserted while o_en=1 with (2,6) loaded
        for (int k = 1; k <= 4; k++) tick(1'b1, W'(k), 1'b1);
        pair("r15", 16'd1, 16'd5, 1'b0);
        tick(1'b1, 16'd6, 1'b1);
        chk_out("r26", 1'b1, 1'b0, 1'b0, 16'd2, 16'd6);
        rst = 1'b1;
        #1;
        chk("async_ready", {66'd0, ready}, 67'd0);
        chk_out("async_out", 1'b0, 1'b0, 1'b0, 16'd0, 16'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 20; k <= 23; k++) tick(1'b1, W'(k), 1'b1);
        chk_idle("post_rst_fill", 16'd0, 16'd0);
        pair("p2024", 16'd20, 16'd24, 1'b0);
        pair("p2125", 16'd21, 16'd25, 1'b0);
        pair("p2226", 16'd22, 16'd26, 1'b0);
        pair("p2327", 16'd23, 16'd27, 1'b1);

        // Extremes pass bit-exact
        tick(1'b1, 16'h8000, 1'b1);
        tick(1'b1, 16'h7FFF, 1'b1);
        tick(1'b1, 16'hFFFF, 1'b1);
        tick(1'b1, 16'h0000, 1'b1);
        pair("x0", 16'h8000, 16'h7FFF, 1'b0);
        pair("x1", 16'h7FFF, 16'h8000, 1'b0);
        pair("x2", 16'hFFFF, 16'h0001, 1'b0);
        pair("x3", 16'h0000, 16'h8000, 1'b1);
        tick(1'b0, 16'd0, 1'b1);
        chk_idle("final_idle", 16'h0000, 16'h8000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fft_pair_buffer.md
FFT_PAIR_BUFFER -- requirements
Module: fft_pair_buffer

Interface
REQ-001 Parameter DATA_FFT_SIZE, default 16: width of each I and Q sample.
REQ-002 Parameter HALF_LEN, default 8: samples per half frame; power of two, at least 2.
REQ-003 i_clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 i_reset  in  1  asynchronous, active-high reset.
REQ-005 i_valid  in  1  input sample valid.
REQ-006 o_ready  out  1  block accepts a sample; transfer occurs on an edge where i_valid and o_ready are both 1.
REQ-007 i_data_i, i_data_q  in  DATA_FFT_SIZE each  input sample, two's complement I/Q.
REQ-008 o_en  out  1  enable for the downstream sum/diff butterfly.
REQ-009 o_phase  out  1  0 = sum cycle, 1 = diff cycle; meaningful only while o_en = 1.
REQ-010 o_data_in0_i, o_data_in0_q  out  DATA_FFT_SIZE each  first-half sample x[n].
REQ-011 o_data_in1_i, o_data_in1_q  out  DATA_FFT_SIZE each  second-half sample x[n+HALF_LEN].
REQ-012 o_last  out  1  marks the final pair of a frame (n = HALF_LEN-1); valid while o_en = 1.

Function
REQ-013 The block SHALL implement three states: FILL, PAIR and HOLD.
REQ-014 The block SHALL drive o_ready = 1 in FILL and PAIR, and o_ready = 0 in HOLD and while i_reset = 1.
REQ-015 FILL: each accepted sample SHALL be written to buffer slot cnt, and cnt SHALL then increment.
REQ-016 FILL: on acceptance with cnt = HALF_LEN-1, cnt SHALL wrap to 0 and the state SHALL change to PAIR.
REQ-017 PAIR: on acceptance, on that same edge:
 - o_data_in0 SHALL load buffer[cnt].
 - o_data_in1 SHALL load the input sample.
 - o_en SHALL be set to 1 and o_phase to 0.
 - o_last SHALL be set to (cnt = HALF_LEN-1).
 - the state SHALL change to HOLD.
REQ-018 HOLD: on the next edge, o_phase SHALL be set to 1 and o_en SHALL remain 1; data and o_last SHALL be held.
REQ-019 HOLD exit: cnt SHALL increment and the state SHALL return to PAIR; if o_last = 1, cnt SHALL wrap to 0 and the state SHALL go to FILL instead.
REQ-020 On the edge leaving HOLD-completed output, o_en SHALL return to 0 unless a new pair is loaded on that edge in PAIR.
 - Net effect: every pair is presented for exactly two consecutive cycles, sum then diff.
 - Back-to-back pairs SHALL give o_en continuously 1 with o_phase alternating 0,1,0,1.
REQ-021 PAIR with i_valid = 0: no state change; o_en = 0 after any completed diff cycle.
REQ-022 o_data outputs SHALL hold their last value while o_en = 0.
REQ-023 Sustained throughput SHALL be one sample per clock in FILL and one sample per two clocks in PAIR.
REQ-024 The block SHALL perform no arithmetic; samples SHALL pass bit-exact at full DATA_FFT_SIZE width.
REQ-025 Buffer storage SHALL be HALF_LEN x 2·DATA_FFT_SIZE bits; a buffer slot SHALL NOT be overwritten before it has been paired.
REQ-026 A new frame's FILL SHALL start on the cycle after the last pair's diff cycle, with no dead cycle beyond that.

Reset
REQ-027 While i_reset = 1, the outputs SHALL be: state = FILL, cnt = 0, o_en = 0, o_phase = 0, o_last = 0, all o_data = 0, o_ready = 0.
REQ-028 Reset asserted mid-frame SHALL discard the partial frame; the first sample accepted after release SHALL be x[0] of a new frame.
REQ-029 Buffer contents need not be cleared by reset.

Verification (HALF_LEN = 4, DATA_FFT_SIZE = 16)
REQ-030 Continuous valid, I = 1..8, Q = -I:
 - Pairs SHALL be (1,5), (2,6), (3,7), (4,8).
 - Each pair SHALL be held 2 cycles, o_phase 0 then 1.
 - o_last SHALL be 1 only on (4,8).
 - o_ready SHALL show the pattern 1,1,1,1, then 1,0 repeating.
REQ-031 Gaps: i_valid toggles 1,0 throughout → the same pairs as REQ-030, with o_en low between pairs and data held.
REQ-032 Two frames back-to-back, samples 1..16:
 - The second frame's pairs SHALL be (9,13) .. (12,16).
 - FILL SHALL begin the cycle after the diff cycle of (4,8).
REQ-033 Reset pulse after sample 6 is accepted, then samples 20..27 are fed → pairs (20,24) .. (23,27), with no stale output.
REQ-034 Extremes: I = 0x8000 and 0x7FFF in pair positions → bit-exact passthrough.
REQ-035 Reset asserted while o_en = 1 → o_en, o_ready and all outputs SHALL be 0 immediately (asynchronous).
